zpower_seq: RTL
===============

Name: zpower_seq

Overview:
- Parametrised multi-rail power sequencer for the photon detector processing board.
- Supersedes the hard-wired single enable: rails are enabled in ascending index order, each gated on its own power-good (PG) input plus a settle delay.
- Rails are disabled in descending order on request. Any PG timeout or PG loss triggers an immediate all-off with a sticky fault.
- Sits between the board controller (request/clear) and the regulator EN/PG pins.

Parameters:
- CHANNELS, 4, number of sequenced rails (1..16).
- CNT_W, 24, width of the shared delay/timeout counter.
- ON_DLY, 100000, settle cycles after PG[k] is seen before enabling rail k+1 or declaring ready (>=1).
- PG_TMO, 1000000, max cycles from oEn[k] rising to PG[k] seen (>=1).
- OFF_DLY, 100000, cycles between successive rail disables (>=1).

Ports:
- iClk  in  1  system clock
- iRst_N  in  1  asynchronous active-low reset
- iStart  in  1  level request: 1 = power up/stay on, 0 = power down
- iClr  in  1  single-cycle pulse, clears a latched fault
- iPG  in  CHANNELS  raw regulator power-good inputs, asynchronous
- oEn  out  CHANNELS  registered regulator enables
- oReady  out  1  all rails up and settled
- oFault  out  1  sticky fault flag
- oFaultCh  out  4  index of the faulting rail
- oBusy  out  1  sequencing in progress (UP/SETTLE/DOWN)

Behaviour:
- Reset is asynchronous and active-low; all logic is clocked on the iClk rising edge.
- Reset values: oEn=0, oReady=0, oFault=0, oFaultCh=0, oBusy=0, counter=0, k=0, state IDLE.
- iPG passes through a 2-FF synchroniser to give pg_s. FSM decisions use pg_s only.
- All outputs are registered.
- States:
  - IDLE: if iStart=1 and oFault=0, go to UP with k=0, set oEn[0]=1, counter=0.
  - UP(k): counter increments each cycle.
    - If pg_s[k]=1: go to SETTLE, counter=0.
    - Else if counter reaches PG_TMO-1: go to FAULT with oFaultCh=k.
    - Worked timing: oEn[k] rises at edge E and raw PG[k] is high before edge E+d. pg_s is high after E+d+1, SETTLE is entered at E+d+2, and the fault (if any) is at edge E+PG_TMO.
  - SETTLE(k): stays exactly ON_DLY cycles.
    - Then if k=CHANNELS-1: go to ON and set oReady=1.
    - Else: k=k+1, set oEn[k]=1, go to UP.
    - Result: oEn[k+1] rises at edge E+d+2+ON_DLY.
  - ON: oReady=1.
    - If any pg_s[i]=0: go to FAULT.
    - Else if iStart=0: oReady=0, go to DOWN with k=CHANNELS-1.
  - DOWN(k): clear oEn[k] on entry, wait OFF_DLY cycles.
    - Then if k=0: go to IDLE.
    - Else: k=k-1 and repeat.
    - iStart is ignored in DOWN; a re-request is honoured only from IDLE.
  - FAULT: entering edge sets oEn=0 (all rails together), oReady=0, oFault=1.
    - Leaves to IDLE only on iClr=1 with iStart=0. The flag clears on that edge.
    - iClr while iStart=1 is ignored.
- PG-loss fault: in UP(k) or SETTLE(k), pg_s[i]=0 for any i<k is a fault; in ON, the check covers all i.
  - oFaultCh = lowest faulting index.
  - PG-loss has priority over the UP timeout: it is flagged on the first edge pg_s drops, and counter expiry is ignored on that edge.
- iStart=0 during UP(k) or SETTLE(k): abort and go to DOWN starting at the current k.
  - The first edge clears oEn[k]; oEn[0..k-1] are cleared afterwards in descending order.
- Simultaneous events: fault beats iStart=0, and iStart=0 beats a SETTLE/UP completion on the same edge.
- oBusy=1 in UP, SETTLE and DOWN; 0 otherwise.
- Reset mid-sequence: all enables drop asynchronously and the FSM returns to IDLE; there is no ordered shutdown.
- Counter width CNT_W must cover max(ON_DLY, PG_TMO, OFF_DLY). The counter saturates and never wraps.

Test Plan (CHANNELS=3, ON_DLY=4, PG_TMO=16, OFF_DLY=3):
- Reset held, iStart=1, iPG=111 -> oEn=000, oReady=0, oFault=0; after release, oEn[0] rises on the first edge.
- Normal up: bench drives iPG[k] 1 cycle (d=1) after oEn[k] -> oEn goes 001, 011, 111 with rising edges 7 cycles apart; oReady=1 7 cycles after oEn[2]; oBusy falls with oReady.
- Power down from ON: iStart=0 -> oEn goes 011, 001, 000 at 3-cycle spacing; oReady=0 on the first edge; IDLE and oBusy=0 after the last wait.
- PG timeout: iPG[1] held 0 -> 16 cycles after oEn[1] rises, oEn=000, oFault=1, oFaultCh=1. iClr with iStart=1 has no effect; iClr with iStart=0 -> oFault=0.
- PG loss in ON: drop iPG[2] -> oEn=000 three edges later (2 sync + 1), oFaultCh=2; iStart=1 held, no restart until cleared.
- Abort: iStart=0 while in SETTLE(1) -> oEn 011 becomes 001 on the next edge, 000 after 3 cycles; oFault stays 0.

Source files
------------

// File: rtl/zpower_seq.sv
// rtl/zpower_seq.sv - multi-rail power sequencer with ordered up/down and sticky fault
//
// Rails are brought up in ascending index order. Each rail waits for its own
// synchronised power-good and then a settle delay before the next rail is enabled.
// Rails are brought down in descending order with a fixed gap between disables.
// A power-good timeout or a loss of power-good on a rail that is already up drops
// every enable at once and latches a fault until the controller clears it.
//
// Ports:
//   iClk      in   1         system clock
//   iRst_N    in   1         asynchronous active-low reset
//   iStart    in   1         level request: 1 = power up / stay on, 0 = power down
//   iClr      in   1         single-cycle pulse, clears a latched fault (only with iStart=0)
//   iPG       in   CHANNELS  raw regulator power-good inputs (asynchronous)
//   oEn       out  CHANNELS  registered regulator enables
//   oReady    out  1         all rails up and settled
//   oFault    out  1         sticky fault flag
//   oFaultCh  out  4         index of the faulting rail
//   oBusy     out  1         sequencing in progress (UP / SETTLE / DOWN)

module zpower_seq #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 24,
    parameter int ON_DLY   = 100000,
    parameter int PG_TMO   = 1000000,
    parameter int OFF_DLY  = 100000
) (
    input  logic                iClk,
    input  logic                iRst_N,
    input  logic                iStart,
    input  logic                iClr,
    input  logic [CHANNELS-1:0] iPG,
    output logic [CHANNELS-1:0] oEn,
    output logic                oReady,
    output logic                oFault,
    output logic [3:0]          oFaultCh,
    output logic                oBusy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_SETTLE,
        S_ON,
        S_DOWN,
        S_FAULT
    } state_t;

    // Terminal counts: the counter starts at 0 on entry to a timed state, so a
    // wait of N cycles ends when the counter holds N-1.
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(PG_TMO - 1);
    localparam logic [CNT_W-1:0] ON_M1  = CNT_W'(ON_DLY - 1);
    localparam logic [CNT_W-1:0] OFF_M1 = CNT_W'(OFF_DLY - 1);
    localparam logic [3:0]       LAST_K = 4'(CHANNELS - 1);

    logic [CHANNELS-1:0] pg_meta_q;
    logic [CHANNELS-1:0] pg_s_q;

    state_t              state_q, state_d;
    logic [3:0]          k_q, k_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic                ready_q, ready_d;
    logic                fault_q, fault_d;
    logic [3:0]          fault_ch_q, fault_ch_d;
    logic                busy_q, busy_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic [CHANNELS-1:0] k_onehot;
    logic [CHANNELS-1:0] below_k;
    logic [CHANNELS-1:0] lost;
    logic [3:0]          lost_idx;
    logic                pg_k;
    logic                do_fault;
    logic [3:0]          do_fault_ch;

    // Two-stage synchroniser for the asynchronous power-good inputs.
    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            pg_meta_q <= '0;
            pg_s_q    <= '0;
        end else begin
            pg_meta_q <= iPG;
            pg_s_q    <= pg_meta_q;
        end
    end

    // Decode the current rail index into a one-hot select and a mask of the
    // rails that are already fully up (indices below k). Built by comparison so
    // that k never has to be used as a bit index narrower than itself.
    always_comb begin
        k_onehot = '0;
        below_k  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            k_onehot[i] = (4'(i) == k_q);
            below_k[i]  = (4'(i) < k_q);
        end
    end

    assign pg_k    = |(pg_s_q & k_onehot);
    // While ON every rail is supervised; while ramping only the rails below k.
    assign lost    = ((state_q == S_ON) ? {CHANNELS{1'b1}} : below_k) & ~pg_s_q;
    // Saturating increment: the counter never wraps back to a small value.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Lowest index of a rail that has lost power-good.
    always_comb begin
        lost_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (lost[i]) begin
                lost_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        en_d        = en_q;
        ready_d     = ready_q;
        fault_d     = fault_q;
        fault_ch_d  = fault_ch_q;
        do_fault    = 1'b0;
        do_fault_ch = '0;

        case (state_q)
            S_IDLE: begin
                if (iStart && !fault_q) begin
                    state_d = S_UP;
                    k_d     = '0;
                    cnt_d   = '0;
                    en_d    = CHANNELS'(1);
                end
            end

            // Priority in both ramp states: fault, then abort, then progress.
            S_UP: begin
                if (|lost) begin
                    do_fault    = 1'b1;
                    do_fault_ch = lost_idx;
                end else if (!pg_k && (cnt_q == TMO_M1)) begin
                    do_fault    = 1'b1;
                    do_fault_ch = k_q;
                end else if (!iStart) begin
                    state_d = S_DOWN;
                    en_d    = en_q & ~k_onehot;
                    cnt_d   = '0;
                end else if (pg_k) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_SETTLE: begin
                if (|lost) begin
                    do_fault    = 1'b1;
                    do_fault_ch = lost_idx;
                end else if (!iStart) begin
                    state_d = S_DOWN;
                    en_d    = en_q & ~k_onehot;
                    cnt_d   = '0;
                end else if (cnt_q == ON_M1) begin
                    cnt_d = '0;
                    if (k_q == LAST_K) begin
                        state_d = S_ON;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_UP;
                        k_d     = k_q + 4'd1;
                        en_d    = en_q | (k_onehot << 1);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_ON: begin
                if (|lost) begin
                    do_fault    = 1'b1;
                    do_fault_ch = lost_idx;
                end else if (!iStart) begin
                    state_d              = S_DOWN;
                    ready_d              = 1'b0;
                    k_d                  = LAST_K;
                    cnt_d                = '0;
                    en_d[CHANNELS-1]     = 1'b0;
                end
            end

            // The rail at k was dropped on entry; after the gap drop the next
            // lower rail. A new request is not looked at until IDLE.
            S_DOWN: begin
                if (cnt_q == OFF_M1) begin
                    cnt_d = '0;
                    if (k_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        k_d  = k_q - 4'd1;
                        en_d = en_q & ~(k_onehot >> 1);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_FAULT: begin
                if (iClr && !iStart) begin
                    state_d = S_IDLE;
                    fault_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                en_d    = '0;
                ready_d = 1'b0;
            end
        endcase

        // All rails are dropped together on a fault; no ordered shutdown.
        if (do_fault) begin
            state_d    = S_FAULT;
            en_d       = '0;
            ready_d    = 1'b0;
            fault_d    = 1'b1;
            fault_ch_d = do_fault_ch;
            cnt_d      = '0;
            k_d        = '0;
        end

        busy_d = (state_d == S_UP) || (state_d == S_SETTLE) || (state_d == S_DOWN);
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            en_q       <= '0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_ch_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
            fault_ch_q <= fault_ch_d;
            busy_q     <= busy_d;
        end
    end

    assign oEn      = en_q;
    assign oReady   = ready_q;
    assign oFault   = fault_q;
    assign oFaultCh = fault_ch_q;
    assign oBusy    = busy_q;

endmodule
